// File: rtl/tx_header_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tx_header_inserter
// Brief    : Prepends a seven-word RDMA header to an AXI-Stream payload and
//            checks the payload byte count against the commanded length.
// Revision : 1.0
// ============================================================================
module tx_header_inserter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_AXIS_TKEEP_WIDTH = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_opcode,
    input  logic [23:0]                   cmd_psn,
    input  logic [23:0]                   cmd_dest_qp,
    input  logic [31:0]                   cmd_remote_addr,
    input  logic [15:0]                   cmd_fragment_offset,
    input  logic [31:0]                   cmd_length,
    input  logic [15:0]                   cmd_partition_key,
    input  logic [7:0]                    cmd_service_level,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
    output logic                          pkt_done,
    output logic                          len_mismatch
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    localparam logic [2:0] C_LAST_HDR_BEAT = 3'd6;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_beat_cnt;
    logic [32:0] r_byte_cnt;
    logic [7:0]  r_opcode;
    logic [23:0] r_psn;
    logic [23:0] r_dest_qp;
    logic [31:0] r_remote_addr;
    logic [15:0] r_fragment_offset;
    logic [31:0] r_length;
    logic [15:0] r_partition_key;
    logic [7:0]  r_service_level;
    logic        r_pkt_done;
    logic        r_len_mismatch;

    logic [31:0] w_hdr_word;
    logic [32:0] w_keep_bytes;
    logic [32:0] w_byte_total;
    logic        w_cmd_accept;
    logic        w_hdr_last_accept;
    logic        w_s_hs;
    logic        w_zero_len;

    assign w_zero_len        = (r_length == 32'd0);
    assign w_cmd_accept      = (r_state == S_IDLE) && cmd_valid;
    assign w_hdr_last_accept = (r_state == S_HEADER) && m_axis_tready
                               && (r_beat_cnt == C_LAST_HDR_BEAT);
    // In PAYLOAD s_axis_tready mirrors m_axis_tready, so this is the s-side handshake
    assign w_s_hs            = (r_state == S_PAYLOAD) && s_axis_tvalid && m_axis_tready;
    assign w_byte_total      = r_byte_cnt + w_keep_bytes;

    always_comb begin
        w_keep_bytes = '0;
        for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
            w_keep_bytes = w_keep_bytes + 33'(s_axis_tkeep[i]);
        end
    end

    always_comb begin
        w_hdr_word = 32'd0;
        case (r_beat_cnt)
            3'd0:    w_hdr_word = {r_psn, r_opcode};
            3'd1:    w_hdr_word = {8'h00, r_dest_qp};
            3'd2:    w_hdr_word = r_remote_addr;
            3'd3:    w_hdr_word = {16'h0000, r_fragment_offset};
            3'd4:    w_hdr_word = r_length;
            3'd5:    w_hdr_word = {16'h0000, r_partition_key};
            3'd6:    w_hdr_word = {24'hABABAB, r_service_level};
            default: w_hdr_word = 32'd0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next_state = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_hdr_last_accept) begin
                    w_next_state = w_zero_len ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_s_hs && s_axis_tlast) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w_hdr_word;
                m_axis_tkeep  = '1;
                m_axis_tlast  = (r_beat_cnt == C_LAST_HDR_BEAT) && w_zero_len;
            end
            S_PAYLOAD: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_beat_cnt        <= 3'd0;
            r_byte_cnt        <= 33'd0;
            r_opcode          <= 8'd0;
            r_psn             <= 24'd0;
            r_dest_qp         <= 24'd0;
            r_remote_addr     <= 32'd0;
            r_fragment_offset <= 16'd0;
            r_length          <= 32'd0;
            r_partition_key   <= 16'd0;
            r_service_level   <= 8'd0;
            r_pkt_done        <= 1'b0;
            r_len_mismatch    <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_opcode          <= cmd_opcode;
                r_psn             <= cmd_psn;
                r_dest_qp         <= cmd_dest_qp;
                r_remote_addr     <= cmd_remote_addr;
                r_fragment_offset <= cmd_fragment_offset;
                r_length          <= cmd_length;
                r_partition_key   <= cmd_partition_key;
                r_service_level   <= cmd_service_level;
                r_beat_cnt        <= 3'd0;
                r_byte_cnt        <= 33'd0;
            end
            if ((r_state == S_HEADER) && m_axis_tready) begin
                r_beat_cnt <= r_beat_cnt + 3'd1;
            end
            if (w_s_hs) begin
                r_byte_cnt <= w_byte_total;
            end
            r_pkt_done     <= (w_hdr_last_accept && w_zero_len) || (w_s_hs && s_axis_tlast);
            r_len_mismatch <= w_s_hs && s_axis_tlast && (w_byte_total != {1'b0, r_length});
        end
    end

    assign pkt_done     = r_pkt_done;
    assign len_mismatch = r_len_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_tx_header_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_header_inserter
// Brief    : Scoreboard bench for tx_header_inserter with directed packets.
// Revision : 1.0
// ============================================================================
module tb_tx_header_inserter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = '0;
    logic [23:0] cmd_psn = '0;
    logic [23:0] cmd_dest_qp = '0;
    logic [31:0] cmd_remote_addr = '0;
    logic [15:0] cmd_fragment_offset = '0;
    logic [31:0] cmd_length = '0;
    logic [15:0] cmd_partition_key = '0;
    logic [7:0]  cmd_service_level = '0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy;
    logic        pkt_done;
    logic        len_mismatch;

    int n_checks = 0;
    int n_errors = 0;
    bit bp_toggle = 1'b0;

    logic [36:0] exp_q[$];
    bit          exp_done_q[$];

    logic        held = 1'b0;
    logic [36:0] held_beat = '0;

    tx_header_inserter #(
        .C_AXIS_TDATA_WIDTH(32),
        .C_AXIS_TKEEP_WIDTH(4)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_opcode         (cmd_opcode),
        .cmd_psn            (cmd_psn),
        .cmd_dest_qp        (cmd_dest_qp),
        .cmd_remote_addr    (cmd_remote_addr),
        .cmd_fragment_offset(cmd_fragment_offset),
        .cmd_length         (cmd_length),
        .cmd_partition_key  (cmd_partition_key),
        .cmd_service_level  (cmd_service_level),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .busy               (busy),
        .pkt_done           (pkt_done),
        .len_mismatch       (len_mismatch)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Sink ready: constant high, or alternating when back-pressure is on
    always @(posedge aclk) begin
        #1;
        if (bp_toggle) m_axis_tready = ~m_axis_tready;
        else           m_axis_tready = 1'b1;
    end

    // Monitor: samples mid-cycle, pops expectations on every output handshake
    always @(negedge aclk) begin
        if (!aresetn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                      {1'b1, held_beat});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", m_axis_tdata);
                end else begin
                    check("m_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
                end
            end
            held      = m_axis_tvalid && !m_axis_tready;
            held_beat = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (pkt_done) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    check("len_mismatch", len_mismatch, exp_done_q.pop_front());
                end
            end else if (len_mismatch) begin
                check("mismatch_without_done", len_mismatch, 1'b0);
            end
        end
    end

    task automatic push_hdr(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, input bit zero_len);
        exp_q.push_back({1'b0, 4'hF, w0});
        exp_q.push_back({1'b0, 4'hF, w1});
        exp_q.push_back({1'b0, 4'hF, w2});
        exp_q.push_back({1'b0, 4'hF, w3});
        exp_q.push_back({1'b0, 4'hF, w4});
        exp_q.push_back({1'b0, 4'hF, w5});
        exp_q.push_back({zero_len, 4'hF, w6});
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] psn, input logic [23:0] qp,
                            input logic [31:0] addr, input logic [15:0] off, input logic [31:0] len,
                            input logic [15:0] pkey, input logic [7:0] sl, input bit exp_mis);
        int t;
        cmd_opcode = op; cmd_psn = psn; cmd_dest_qp = qp; cmd_remote_addr = addr;
        cmd_fragment_offset = off; cmd_length = len; cmd_partition_key = pkey;
        cmd_service_level = sl; cmd_valid = 1'b1;
        exp_done_q.push_back(exp_mis);
        t = 0;
        @(negedge aclk);
        while (!cmd_ready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 200) timeout("cmd_accept");
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input bit last);
        int t;
        s_axis_tdata = data; s_axis_tkeep = keep; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        exp_q.push_back({last, keep, data});
        t = 0;
        @(negedge aclk);
        while (!s_axis_tready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 200) timeout("s_handshake");
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge aclk);
        while (!pkt_done && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 200) timeout("pkt_done");
        @(posedge aclk); #1;
    endtask

    initial begin
        int t;
        int rdy_cnt;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_m_tdata", m_axis_tdata, 32'd0);
        check("rst_pkt_done", pkt_done, 1'b0);
        @(posedge aclk); #1;

        // Basic packet; payload presented early must wait behind the header
        push_hdr(32'h0000050A, 32'h00000011, 32'h10000000, 32'h00000000,
                 32'h00000008, 32'h0000FFFF, 32'hABABAB03, 1'b0);
        send_cmd(8'h0A, 24'h000005, 24'h000011, 32'h1000_0000, 16'h0000, 32'd8,
                 16'hFFFF, 8'h03, 1'b0);
        check("busy_in_pkt", busy, 1'b1);
        check("cmd_ready_in_pkt", cmd_ready, 1'b0);
        send_beat(32'hCAFE0001, 4'hF, 1'b0);
        send_beat(32'hCAFE0002, 4'hF, 1'b1);
        wait_done();
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Back-pressure: sink ready alternates every cycle
        bp_toggle = 1'b1;
        push_hdr(32'h12345604, 32'h00ABCDEF, 32'hDEADBEEF, 32'h00000040,
                 32'h0000000C, 32'h00008001, 32'hABABAB07, 1'b0);
        send_cmd(8'h04, 24'h123456, 24'hABCDEF, 32'hDEAD_BEEF, 16'h0040, 32'd12,
                 16'h8001, 8'h07, 1'b0);
        send_beat(32'h11111111, 4'hF, 1'b0);
        send_beat(32'h22222222, 4'hF, 1'b0);
        send_beat(32'h33333333, 4'hF, 1'b1);
        wait_done();
        bp_toggle = 1'b0;

        // Zero length: stray payload must stay back-pressured for the whole packet
        push_hdr(32'h00010011, 32'h00000022, 32'h00000004, 32'h00001234,
                 32'h00000000, 32'h00007FFF, 32'hABABAB00, 1'b1);
        send_cmd(8'h11, 24'h000100, 24'h000022, 32'h0000_0004, 16'h1234, 32'd0,
                 16'h7FFF, 8'h00, 1'b0);
        s_axis_tdata = 32'hDEAD0000; s_axis_tkeep = 4'hF; s_axis_tvalid = 1'b1;
        rdy_cnt = 0;
        t = 0;
        @(negedge aclk);
        while (!pkt_done && t < 200) begin
            if (s_axis_tready) rdy_cnt++;
            @(negedge aclk);
            t++;
        end
        if (t >= 200) timeout("zero_len_done");
        check("zero_len_s_tready", s_axis_tready, 1'b0);
        check("zero_len_ready_cycles", rdy_cnt, 0);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;

        // Length mismatch: 10 bytes delivered against length 8, all forwarded
        push_hdr(32'h0000060A, 32'h00000011, 32'h10000100, 32'h00000000,
                 32'h00000008, 32'h0000FFFF, 32'hABABAB03, 1'b0);
        send_cmd(8'h0A, 24'h000006, 24'h000011, 32'h1000_0100, 16'h0000, 32'd8,
                 16'hFFFF, 8'h03, 1'b1);
        send_beat(32'hA0A0A0A0, 4'hF, 1'b0);
        send_beat(32'hB0B0B0B0, 4'hF, 1'b0);
        send_beat(32'h0000C0C0, 4'h3, 1'b1);
        wait_done();

        // Reset during header beat 3
        push_hdr(32'h0000070A, 32'h00000011, 32'h10000000, 32'h00000000,
                 32'h00000008, 32'h0000FFFF, 32'hABABAB03, 1'b0);
        send_cmd(8'h0A, 24'h000007, 24'h000011, 32'h1000_0000, 16'h0000, 32'd8,
                 16'hFFFF, 8'h03, 1'b0);
        t = 0;
        @(negedge aclk);
        while (!(m_axis_tvalid && m_axis_tready && m_axis_tdata == 32'h10000000) && t < 50) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 50) timeout("reach_beat2");
        @(posedge aclk); #1;
        check("beat3_present", m_axis_tdata, 32'h00000000);
        aresetn = 1'b0;
        exp_q.delete();
        exp_done_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        check("post_rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        @(posedge aclk); #1;

        push_hdr(32'h0000080A, 32'h00000011, 32'h10000200, 32'h00000010,
                 32'h00000004, 32'h0000FFFF, 32'hABABAB03, 1'b0);
        send_cmd(8'h0A, 24'h000008, 24'h000011, 32'h1000_0200, 16'h0010, 32'd4,
                 16'hFFFF, 8'h03, 1'b0);
        send_beat(32'h5A5A5A5A, 4'hF, 1'b1);
        wait_done();

        repeat (3) @(posedge aclk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
